// File: rtl/irq_controller_pkg.sv
// Shared constants and types for the six-source interrupt controller.
// Register word offsets are bus_addr[4:2].
package irq_controller_pkg;
  localparam logic [31:0] IRQ_BASE_DEFAULT = 32'h0000_7F40;
  localparam int          IRQ_NSRC         = 6;

  typedef enum logic [2:0] {
    IRQ_CTRL = 3'd0,
    IRQ_MASK = 3'd1,
    IRQ_MODE = 3'd2,
    IRQ_PEND = 3'd3,
    IRQ_SOFT = 3'd4,
    IRQ_ID   = 3'd5
  } irq_off_e;

  typedef struct packed {
    logic                gie;
    logic [IRQ_NSRC-1:0] mask;
    logic [IRQ_NSRC-1:0] mode;
  } irq_cfg_t;
endpackage

// File: rtl/irq_src_cell.sv
// Per-source state: input sample register and sticky edge-pending bit.
// The pending view selects between the edge latch and the sampled level.
module irq_src_cell (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mode,
  input  logic clr,
  input  logic soft_set,
  input  logic mode_chg,
  output logic pend
);
  logic src_q, pend_e, rise;

  assign rise = src & ~src_q;

  // src_q resets high so a source held across reset does not look like an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= 1'b1;
      pend_e <= 1'b0;
    end else begin
      src_q  <= src;
      pend_e <= (pend_e & ~(clr | mode_chg)) | (rise & mode) | soft_set;
    end
  end

  assign pend = mode ? pend_e : src_q;
endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: decode, CTRL/MASK/MODE registers,
// lowest-index-first ID encoder, read mux and registered HWInt.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IRQ_BASE_DEFAULT,
  parameter int          N_SRC     = IRQ_NSRC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  src_irq,
  input  logic [31:0]       bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic [3:0]        bus_byteen,
  output logic [31:0]       bus_rdata,
  output logic [N_SRC-1:0]  HWInt
);
  irq_cfg_t         cfg;
  logic [2:0]       off;
  logic             sel, wr;
  logic [N_SRC-1:0] wd, clr, soft_set, mode_chg, pend, act;
  logic [7:0]       id;
  logic             unused_bits;

  assign off = bus_addr[4:2];
  assign sel = (bus_addr[31:5] == BASE_ADDR[31:5]) && (off <= 3'd5);
  assign wr  = sel && bus_byteen[0];
  assign wd  = bus_wdata[N_SRC-1:0];
  assign unused_bits = ^{bus_wdata[31:N_SRC], bus_byteen[3:1], bus_addr[1:0]};

  assign clr      = (wr && off == IRQ_PEND) ? wd : '0;
  assign soft_set = (wr && off == IRQ_SOFT) ? wd : '0;
  assign mode_chg = (wr && off == IRQ_MODE) ? (wd ^ cfg.mode) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg <= '0;
    end else if (wr) begin
      case (off)
        IRQ_CTRL: cfg.gie  <= bus_wdata[0];
        IRQ_MASK: cfg.mask <= wd;
        IRQ_MODE: cfg.mode <= wd;
        default: ;
      endcase
    end
  end

  irq_src_cell u_cell [N_SRC-1:0] (
    .clk      (clk),
    .reset    (reset),
    .src      (src_irq),
    .mode     (cfg.mode),
    .clr      (clr),
    .soft_set (soft_set),
    .mode_chg (mode_chg),
    .pend     (pend)
  );

  assign act = {N_SRC{cfg.gie}} & cfg.mask & pend;

  always_ff @(posedge clk) begin
    if (reset) HWInt <= '0;
    else       HWInt <= act;
  end

  // Scan high to low so the lowest active index wins
  always_comb begin
    id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (act[i]) id = 8'(i + 1);
  end

  always_comb begin
    bus_rdata = '0;
    if (sel) begin
      case (off)
        IRQ_CTRL: bus_rdata[0]         = cfg.gie;
        IRQ_MASK: bus_rdata[N_SRC-1:0] = cfg.mask;
        IRQ_MODE: bus_rdata[N_SRC-1:0] = cfg.mode;
        IRQ_PEND: bus_rdata[N_SRC-1:0] = pend;
        IRQ_ID:   bus_rdata[7:0]       = id;
        default:  bus_rdata            = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// Randomized and directed check of irq_controller against a per-cycle
// behavioural model of the register map and pending rules.
module tb_irq_controller;
  localparam logic [31:0] BASE = 32'h0000_7F40;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_irq;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen;
  logic [5:0]  HWInt;

  irq_controller #(.BASE_ADDR(BASE), .N_SRC(6)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_byteen(bus_byteen), .bus_rdata(bus_rdata),
    .HWInt(HWInt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference state
  bit       m_gie;
  bit [5:0] m_mask, m_mode, m_srcq, m_pe, m_hw;
  bit [5:0] cur_src;
  logic [31:0] rd_obs;
  logic [5:0]  hw_obs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [5:0] m_pend();
    bit [5:0] p;
    for (int i = 0; i < 6; i++) p[i] = m_mode[i] ? m_pe[i] : m_srcq[i];
    return p;
  endfunction

  function automatic int m_id();
    bit [5:0] a;
    a = m_gie ? (m_pend() & m_mask) : 6'd0;
    for (int i = 0; i < 6; i++) if (a[i]) return i + 1;
    return 0;
  endfunction

  function automatic bit m_sel(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'd24);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_sel(a)) return 32'd0;
    case ((a - BASE) / 4)
      0: return {31'd0, m_gie};
      1: return {26'd0, m_mask};
      2: return {26'd0, m_mode};
      3: return {26'd0, m_pend()};
      5: return 32'(m_id());
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step(input logic r, input bit [5:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    bit [5:0] dd, clrm, setm, nxt;
    int w;
    bit we;
    if (r) begin
      m_gie = 0; m_mask = 0; m_mode = 0; m_pe = 0; m_hw = 0; m_srcq = 6'h3F;
      return;
    end
    we = m_sel(a) && be[0];
    w  = (a - BASE) / 4;
    dd = d[5:0];
    clrm = 0; setm = 0;
    for (int i = 0; i < 6; i++) begin
      if (s[i] && !m_srcq[i] && m_mode[i]) setm[i] = 1;
      if (we && w == 4 && dd[i]) setm[i] = 1;
      if (we && w == 3 && dd[i]) clrm[i] = 1;
      if (we && w == 2 && dd[i] != m_mode[i]) clrm[i] = 1;
    end
    for (int i = 0; i < 6; i++) nxt[i] = setm[i] ? 1'b1 : (clrm[i] ? 1'b0 : m_pe[i]);
    m_hw = m_gie ? (m_mask & m_pend()) : 6'd0;
    m_pe = nxt;
    m_srcq = s;
    if (we && w == 0) m_gie  = d[0];
    if (we && w == 1) m_mask = dd;
    if (we && w == 2) m_mode = dd;
  endtask

  task automatic cyc(input logic r, input bit [5:0] s, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    reset = r; src_irq = s; bus_addr = a; bus_wdata = d; bus_byteen = be;
    #1;
    rd_obs = bus_rdata;
    chk("rdata", bus_rdata, m_read(a));
    @(posedge clk);
    m_step(r, s, a, d, be);
    #1;
    hw_obs = HWInt;
    chk("hwint", {26'd0, HWInt}, {26'd0, m_hw});
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    cyc(1'b0, cur_src, BASE + 32'(off), d, 4'hF);
  endtask

  task automatic rd(input int off);
    cyc(1'b0, cur_src, BASE + 32'(off), 32'd0, 4'h0);
  endtask

  initial begin
    int hi_cnt;
    m_srcq = 6'h3F;
    // reset with all sources high, then check every offset
    cur_src = 6'h3F;
    cyc(1'b1, cur_src, 32'd0, 32'd0, 4'h0);
    cyc(1'b1, cur_src, 32'd0, 32'd0, 4'h0);
    chk("reset_hw", {26'd0, hw_obs}, 32'd0);
    for (int o = 0; o < 24; o += 4) begin
      rd(o);
      if (o != 12) chk("reset_reg", rd_obs, 32'd0);
    end
    wr(8, 32'h3F);
    rd(12);
    chk("no_edge_after_reset", rd_obs, 32'd0);
    cur_src = 0;
    wr(8, 32'h0);

    // edge source, 2-cycle latency
    wr(0, 1); wr(4, 32'h04); wr(8, 32'h04); rd(0);
    cur_src = 6'h04; rd(20);
    chk("edge_lat1", {26'd0, hw_obs}, 32'd0);
    cur_src = 6'h00; rd(20);
    chk("edge_id", rd_obs, 32'd3);
    chk("edge_lat2", {26'd0, hw_obs}, 32'h04);
    wr(12, 32'h04);
    chk("w1c_lat1", {26'd0, hw_obs}, 32'h04);
    rd(0);
    chk("w1c_lat2", {26'd0, hw_obs}, 32'd0);

    // level source held 5 cycles, W1C ignored
    wr(8, 0); wr(4, 32'h01);
    hi_cnt = 0;
    cur_src = 6'h01;
    wr(12, 32'h01); hi_cnt += hw_obs[0];
    for (int k = 0; k < 4; k++) begin rd(12); hi_cnt += hw_obs[0]; end
    cur_src = 6'h00;
    for (int k = 0; k < 5; k++) begin rd(0); hi_cnt += hw_obs[0]; end
    chk("level_cycles", 32'(hi_cnt), 32'd5);

    // priority and mask
    wr(8, 32'h3F); wr(16, 32'h28); wr(4, 32'h20);
    rd(20); chk("prio_m20", rd_obs, 32'd6);
    wr(4, 32'h3F);
    rd(20); chk("prio_m3f", rd_obs, 32'd4);
    wr(0, 0);
    rd(20); chk("prio_gie0", rd_obs, 32'd0);
    rd(0);  chk("gie0_hw", {26'd0, hw_obs}, 32'd0);

    // rise on bit1 together with its W1C; then soft set of bit4
    wr(12, 32'h3F); wr(0, 1);
    cur_src = 6'h02; wr(12, 32'h02);
    rd(12); chk("set_beats_clr", rd_obs & 32'h02, 32'h02);
    wr(16, 32'h10); rd(0);
    chk("soft_hw4", {31'd0, hw_obs[4]}, 32'd1);

    // decode: reserved offset and masked byte enable change nothing
    cur_src = 0;
    wr(24, 32'h3F);
    cyc(1'b0, cur_src, BASE + 32'd4, 32'h0, 4'hE);
    rd(4); chk("mask_kept", rd_obs, 32'h3F);
    rd(5); chk("unaligned_rd", rd_obs, 32'h3F);
    cyc(1'b0, cur_src, BASE + 32'd32, 32'd0, 4'h0);
    chk("outside_hi", rd_obs, 32'd0);
    cyc(1'b0, cur_src, BASE - 32'd4, 32'd0, 4'h0);
    chk("outside_lo", rd_obs, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d;
      logic [3:0]  be;
      logic        r;
      if ($urandom_range(0, 3) == 0) cur_src = cur_src ^ 6'($urandom);
      a  = ($urandom_range(0, 9) < 8) ? BASE + 32'($urandom_range(0, 31)) : $urandom;
      d  = $urandom;
      be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      r  = ($urandom_range(0, 199) == 0);
      cyc(r, cur_src, a, d, be);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
